fft_frame_loader: RTL and testbench
===================================

// Module: fft_frame_loader
// PURPOSE
//  Streaming front end for the 32-point radix-2 DIT butterfly array; it replaces the file-loaded sample ROM.
//  Accepts real time-domain samples one per cycle over a valid/ready handshake and assembles them into frames.
//  Each frame is stored in one of two ping-pong banks and presented as one flat bus in bit-reversed order.
//  Column-0 butterflies take slot pairs (2m, 2m+1) directly, i.e. x[0]/x[16], x[8]/x[24], ...
// PARAMETERS
//  N      32  samples per frame (power of two; verified at 32 only)
//  LOG2N  5   log2(N); width of the sample counter and of the bit-reverse index
//  DW     32  sample width in bits (real part only; imaginary part is zero-filled downstream)
// PORTS
//  clk          in   1     rising-edge clock; the block's only clock
//  rst_n        in   1     asynchronous active-low reset
//  s_valid      in   1     input sample valid
//  s_ready      out  1     block can accept a sample this cycle
//  s_data       in   DW    input sample, two's complement
//  s_last       in   1     marks the last sample of a frame; qualified by s_valid&&s_ready
//  frame_valid  out  1     frame_data holds a complete frame
//  frame_ready  in   1     downstream consumes the frame this cycle
//  frame_data   out  N*DW  slot k = frame_data[DW*k +: DW] = sample index bitrev(k) of the frame
//  frame_err    out  1     one-cycle pulse on a framing error
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 (s_ready is 0 during reset).
//  - wr_bank=0, rd_bank=0, count=0, full[1:0]=0; bank contents are don't-care.
//  - Reset takes effect at any time. A partial frame is dropped, and so are held frames. No frame_valid follows.
//  Accept (s_valid&&s_ready):
//  - Write s_data to bank[wr_bank] slot bitrev(count); count <= count+1.
//  - Completion = accepted sample with count==N-1. Then full[wr_bank]<=1, wr_bank toggles, count<=0.
//  - s_ready = !full[wr_bank] (registered state only, no combinational path from frame_ready).
//  Output:
//  - frame_valid = full[rd_bank]; frame_data is muxed from bank[rd_bank].
//  - On frame_valid&&frame_ready: full[rd_bank]<=0 and rd_bank toggles.
//  - While frame_valid && !frame_ready, frame_data and frame_valid hold stable.
//  Latency and throughput:
//  - frame_valid rises the cycle after the accepted N-th sample, when that bank is next in read order.
//  - Sustained rate is 1 sample/cycle while downstream takes each frame within N cycles.
//  - s_ready drops only when both banks are full.
//  Simultaneous events:
//  - Completion into one bank and release of the other bank in the same cycle both take effect.
//  - The freed bank then accepts input on the following cycle.
//  Framing (s_last):
//  - Early last: s_last accepted with count<N-1. The partial frame is discarded and count<=0. The bank is not marked full. frame_err pulses.
//  - Missing last: count==N-1 accepted without s_last. The frame is still completed and presented. frame_err pulses.
//  - s_last is ignored unless s_valid&&s_ready.
//  Width rules:
//  - Samples are stored and forwarded bit-exact; no arithmetic.
//  - bitrev(k) reverses the LOG2N-bit index k.
// TESTING
//  1. Reset: hold rst_n=0 -> s_ready=0, frame_valid=0, frame_err=0. Release -> s_ready=1 on the first edge after release.
//  2. Ramp 0..31 with s_last on 31, frame_ready=1 -> frame_valid 1 cycle after sample 31.
//     Expected slots: slot0=0, slot1=16, slot2=8, slot3=24, slot30=15, slot31=31. Pulse is 1 cycle; frame_err stays 0.
//  3. frame_ready=0, stream 64 samples (two frames) -> both accepted; s_ready=0 on the 65th.
//     Then frame_ready=1 for one cycle -> frame A released, frame B shown next cycle, s_ready=1 again.
//  4. s_last on the 10th sample -> frame_err pulses, no frame. The next 32 samples (0x100..0x11F) form a frame with slot1=0x110.
//  5. 32 samples with s_last never asserted -> frame presented normally and frame_err pulses on the cycle after the 32nd sample.
//  6. rst_n low after 20 samples while a full frame is held -> after release: frame_valid=0, count restarts.
//     A fresh 32-sample frame is output correctly, with no stale slots.

Source files
------------

// File: rtl/fft_frame_loader.sv
// Streaming front end for the 32-point radix-2 DIT butterfly array: packs samples into
// ping-pong frame banks and presents the held frame as one flat bus in bit-reversed order.
module fft_frame_loader #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic              s_last,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [N*DW-1:0]   frame_data,
  output logic              frame_err
);

  logic             init_q;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] count_q, count_d;
  logic [1:0]       full_q, full_d;
  logic             err_q, err_d;
  logic [DW-1:0]    bank_q [2][N];

  logic accept;
  logic frame_take;
  logic last_slot;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  // init_q keeps s_ready low through reset and until the first edge after release.
  assign s_ready     = init_q && !full_q[wr_bank_q];
  assign frame_valid = full_q[rd_bank_q];
  assign frame_err   = err_q;
  assign accept      = s_valid && s_ready;
  assign frame_take  = frame_valid && frame_ready;
  assign last_slot   = (count_q == LOG2N'(N-1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    count_d   = count_q;
    full_d    = full_q;
    err_d     = 1'b0;

    // Release and completion always hit different banks, so both may land together.
    if (frame_take) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    if (accept) begin
      if (last_slot) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        count_d           = '0;
        err_d             = !s_last;
      end else if (s_last) begin
        count_d = '0;
        err_d   = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      count_q   <= '0;
      full_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      init_q    <= 1'b1;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      count_q   <= count_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  // NOTE: sample storage has no reset; full_q alone decides whether bank contents mean anything.
  always_ff @(posedge clk) begin
    if (accept) bank_q[wr_bank_q][bitrev(count_q)] <= s_data;
  end

  // Bus is zero whenever no frame is held, which also covers the reset state.
  always_comb begin
    frame_data = '0;
    for (int k = 0; k < N; k++) begin
      if (frame_valid) frame_data[DW*k +: DW] = bank_q[rd_bank_q][k];
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed framing scenarios followed by a random phase,
// all compared against a queue-of-frames reference model.
module tb_fft_frame_loader;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 32;

  typedef logic [DW-1:0] frame_t [N];

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            s_last;
  logic            frame_valid;
  logic            frame_ready;
  logic [N*DW-1:0] frame_data;
  logic            frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model: completed frames awaiting release, the frame being assembled,
  // whether the block is out of reset, and the pending error pulse.
  frame_t        pend[$];
  logic [DW-1:0] part[$];
  bit            m_init;
  bit            m_err;

  fft_frame_loader #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  function automatic int bitrev_idx(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      if (((k >> i) & 1) != 0) r = r | (1 << (LOG2N - 1 - i));
    end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] expected_bus(input frame_t f);
    logic [N*DW-1:0] bus;
    bus = '0;
    for (int k = 0; k < N; k++) bus[DW*k +: DW] = f[bitrev_idx(k)];
    return bus;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    int bad;
    checks++;
    assert (obs === exp) else begin
      errors++;
      bad = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (obs[DW*k +: DW] !== exp[DW*k +: DW]) bad = k;
      end
      $error("FAIL %s slot%0d observed=%0h expected=%0h", tag, bad,
             obs[DW*bad +: DW], exp[DW*bad +: DW]);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":s_ready"},     DW'(s_ready),     DW'(m_init && pend.size() < 2));
    chk({tag, ":frame_valid"}, DW'(frame_valid), DW'(pend.size() > 0));
    chk({tag, ":frame_err"},   DW'(frame_err),   DW'(m_err));
    if (pend.size() > 0) chk_bus({tag, ":frame_data"}, frame_data, expected_bus(pend[0]));
  endtask

  // One clock cycle: drive inputs, advance the model by the spec's accept/release rules, check.
  task automatic step(input string tag, input logic v, input logic l,
                      input logic [DW-1:0] d, input logic fr);
    bit     acc;
    bit     rel;
    frame_t f;
    s_valid     = v;
    s_last      = l;
    s_data      = d;
    frame_ready = fr;
    acc = v && m_init && (pend.size() < 2);
    rel = fr && (pend.size() > 0);
    @(posedge clk);
    if (rel) pend.delete(0);
    m_err = 1'b0;
    if (acc) begin
      part.push_back(d);
      if (part.size() == N) begin
        for (int i = 0; i < N; i++) f[i] = part[i];
        pend.push_back(f);
        m_err = !l;
        part.delete();
      end else if (l) begin
        part.delete();
        m_err = 1'b1;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = '0;
    frame_ready = 1'b0;
    rst_n       = 1'b0;
    pend.delete();
    part.delete();
    m_init = 1'b0;
    m_err  = 1'b0;
    #1;
    chk("rst_async:s_ready",     DW'(s_ready),     '0);
    chk("rst_async:frame_valid", DW'(frame_valid), '0);
    chk("rst_async:frame_err",   DW'(frame_err),   '0);
    chk_bus("rst_async:frame_data", frame_data, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held:s_ready",     DW'(s_ready),     '0);
    chk("rst_held:frame_valid", DW'(frame_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_init = 1'b1;
    #1;
    check_all("rst_release");
  endtask

  initial begin
    logic lst;
    rst_n       = 1'b1;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = '0;
    frame_ready = 1'b0;
    m_init      = 1'b0;
    m_err       = 1'b0;
    #3;

    // Reset behaviour.
    do_reset();

    // Ramp frame with downstream always ready.
    for (int i = 0; i < N; i++) step("ramp", 1'b1, i == N - 1, DW'(i), 1'b1);
    chk("ramp:slot0",  frame_data[DW*0  +: DW], 32'd0);
    chk("ramp:slot1",  frame_data[DW*1  +: DW], 32'd16);
    chk("ramp:slot2",  frame_data[DW*2  +: DW], 32'd8);
    chk("ramp:slot3",  frame_data[DW*3  +: DW], 32'd24);
    chk("ramp:slot30", frame_data[DW*30 +: DW], 32'd15);
    chk("ramp:slot31", frame_data[DW*31 +: DW], 32'd31);
    step("ramp_pulse", 1'b0, 1'b0, '0, 1'b1);

    // Two frames with downstream stalled, then a single release cycle.
    for (int i = 0; i < 2 * N; i++) step("stall_fill", 1'b1, (i % N) == N - 1, $urandom, 1'b0);
    chk("stall:s_ready_low", DW'(s_ready), '0);
    step("stall_65th", 1'b1, 1'b0, $urandom, 1'b0);
    step("release_a", 1'b0, 1'b0, '0, 1'b1);
    chk("release_a:s_ready", DW'(s_ready), 32'd1);
    step("release_b", 1'b0, 1'b0, '0, 1'b1);

    // Early last on the 10th sample, then a clean frame.
    for (int i = 0; i < 10; i++) step("early_last", 1'b1, i == 9, $urandom, 1'b1);
    chk("early_last:err", DW'(frame_err), 32'd1);
    for (int i = 0; i < N; i++) step("after_early", 1'b1, i == N - 1, 32'h100 + DW'(i), 1'b1);
    chk("after_early:slot1", frame_data[DW*1 +: DW], 32'h110);
    step("after_early_rel", 1'b0, 1'b0, '0, 1'b1);

    // Frame with s_last never asserted.
    for (int i = 0; i < N; i++) step("no_last", 1'b1, 1'b0, $urandom, 1'b1);
    chk("no_last:err",   DW'(frame_err),   32'd1);
    chk("no_last:valid", DW'(frame_valid), 32'd1);
    step("no_last_rel", 1'b0, 1'b0, '0, 1'b1);

    // Reset while one frame is held and another is partially loaded.
    for (int i = 0; i < N; i++) step("pre_rst_full", 1'b1, i == N - 1, $urandom, 1'b0);
    for (int i = 0; i < 20; i++) step("pre_rst_part", 1'b1, 1'b0, $urandom, 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) step("post_rst", 1'b1, i == N - 1, 32'hA000 + DW'(i), 1'b0);
    step("post_rst_hold", 1'b0, 1'b0, '0, 1'b0);
    step("post_rst_rel", 1'b0, 1'b0, '0, 1'b1);

    // Random traffic with mostly well-formed framing.
    for (int c = 0; c < 1500; c++) begin
      if (part.size() == N - 1) lst = ($urandom_range(0, 7) != 0);
      else                      lst = ($urandom_range(0, 40) == 0);
      step("random", $urandom_range(0, 3) != 0, lst, $urandom,
           (c / 100) % 2 == 0 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
